// File: rtl/spi_txn_arbiter.sv
// Round-robin owner of one SPI master: applies the winner's mode word,
// runs its burst, moves TX/RX words and selects its slave.
module spi_txn_arbiter #(
    parameter int NumReq     = 4,
    parameter int WordLen    = 8,
    parameter int LenW       = 4,
    parameter int SetupCyc   = 2,
    parameter int GapCyc     = 4,
    parameter int TimeoutCyc = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NumReq-1:0]           Req,
    input  logic [NumReq*LenW-1:0]      ReqWords,
    input  logic [NumReq*4-1:0]         ReqCfg,
    input  logic [NumReq*WordLen-1:0]   ReqTxData,
    output logic [NumReq-1:0]           Grant,
    output logic                        TxPop,
    output logic                        RxValid,
    output logic [WordLen-1:0]          RxData,
    output logic                        Done,
    output logic                        Error,
    output logic [NumReq-1:0]           SlaveSel_n,
    output logic                        SPIGo,
    output logic                        CPOL,
    output logic                        CPHA,
    output logic                        SPIMode,
    output logic                        Endianess,
    output logic [WordLen-1:0]          SendData,
    input  logic                        SS,
    input  logic                        TxBusy,
    input  logic                        RxBusy,
    input  logic                        WordFlg,
    input  logic [WordLen-1:0]          ReceivedData
);

    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int SetW = $clog2(SetupCyc + 1);
    localparam int GapW = $clog2(GapCyc + 1);
    localparam int ToW  = $clog2(TimeoutCyc + 1);

    typedef enum logic [2:0] {
        IDLE, ARB, SETUP, RUN, DRAIN, GAP
    } state_t;

    state_t state, nextState;

    logic [PtrW-1:0] ptr, gIdx, winner, cand;
    logic            found;
    logic [LenW-1:0] wordsM1, wordCnt;
    logic [SetW-1:0] setupCnt;
    logic [GapW-1:0] gapCnt;
    logic [ToW-1:0]  toCnt;
    logic            rxPend, reloadPend;
    logic            wordHit, lastWord, toHit;
    logic            drainOk, setupDone, gapDone;

    assign wordHit   = (state == RUN) && WordFlg;
    assign lastWord  = wordHit && (wordCnt == wordsM1);
    assign toHit     = ((state == RUN) || (state == DRAIN)) && !wordHit
                       && (toCnt == ToW'(TimeoutCyc - 1));
    assign drainOk   = (state == DRAIN) && !TxBusy && !RxBusy && !rxPend;
    assign setupDone = (state == SETUP) && (setupCnt == SetW'(SetupCyc - 1));
    assign gapDone   = (state == GAP) && (gapCnt == GapW'(GapCyc - 1));

    assign SPIGo      = (state == RUN);
    assign SlaveSel_n = ~(Grant & {NumReq{~SS}});

    // First requester at or after the pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (int'(ptr) + k >= NumReq)
                cand = PtrW'(int'(ptr) + k - NumReq);
            else
                cand = PtrW'(int'(ptr) + k);
            if (!found && Req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (|Req) nextState = ARB;
            ARB:     nextState = found ? SETUP : IDLE;
            SETUP:   if (setupDone) nextState = RUN;
            RUN: begin
                if (toHit)         nextState = GAP;
                else if (lastWord) nextState = DRAIN;
            end
            DRAIN:   if (toHit || drainOk) nextState = GAP;
            GAP:     if (gapDone) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Grant      <= '0;
            ptr        <= '0;
            gIdx       <= '0;
            wordsM1    <= '0;
            wordCnt    <= '0;
            setupCnt   <= '0;
            gapCnt     <= '0;
            toCnt      <= '0;
            CPOL       <= 1'b0;
            CPHA       <= 1'b0;
            SPIMode    <= 1'b0;
            Endianess  <= 1'b0;
            SendData   <= '0;
            RxData     <= '0;
            TxPop      <= 1'b0;
            RxValid    <= 1'b0;
            Done       <= 1'b0;
            Error      <= 1'b0;
            rxPend     <= 1'b0;
            reloadPend <= 1'b0;
        end else begin
            TxPop      <= wordHit && !lastWord;
            reloadPend <= TxPop;
            rxPend     <= wordHit;
            RxValid    <= rxPend && !toHit;
            Done       <= drainOk || toHit;
            Error      <= toHit;
            // Master's RX register settles one clk after WordFlg.
            if (rxPend && !toHit)
                RxData <= ReceivedData;
            // Requester advanced its word on the TxPop edge.
            if (reloadPend)
                SendData <= ReqTxData[int'(gIdx)*WordLen +: WordLen];
            if (state != SETUP) setupCnt <= '0;
            if (state != GAP)   gapCnt   <= '0;
            unique case (state)
                IDLE: ;
                ARB: begin
                    if (found) begin
                        Grant         <= '0;
                        Grant[winner] <= 1'b1;
                        gIdx          <= winner;
                        ptr           <= (winner == PtrW'(NumReq - 1))
                                         ? '0 : winner + 1'b1;
                        wordsM1       <= ReqWords[int'(winner)*LenW +: LenW];
                        wordCnt       <= '0;
                        {CPOL, CPHA, SPIMode, Endianess}
                                      <= ReqCfg[int'(winner)*4 +: 4];
                        SendData      <= ReqTxData[int'(winner)*WordLen +: WordLen];
                    end
                end
                SETUP: begin
                    setupCnt <= setupCnt + 1'b1;
                    if (setupDone) toCnt <= '0;
                end
                RUN: begin
                    toCnt <= wordHit ? '0 : toCnt + 1'b1;
                    if (wordHit) wordCnt <= wordCnt + 1'b1;
                end
                DRAIN: toCnt <= toCnt + 1'b1;
                GAP: begin
                    Grant  <= '0;
                    gapCnt <= gapCnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: echoing SPI master model, stepping
// requesters, and a queue of expected grants and RX words.
module tb_spi_txn_arbiter;

    localparam int NR = 4;
    localparam int WL = 8;
    localparam int LW = 4;
    localparam int SC = 2;
    localparam int GC = 4;
    localparam int TO = 64;
    localparam int WORD_CYC = 6;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     Req;
    logic [NR*LW-1:0]  ReqWords;
    logic [NR*4-1:0]   ReqCfg;
    logic [NR*WL-1:0]  ReqTxData;
    logic [NR-1:0]     Grant;
    logic              TxPop, RxValid, Done, Error;
    logic [WL-1:0]     RxData, SendData, ReceivedData;
    logic [NR-1:0]     SlaveSel_n;
    logic              SPIGo, CPOL, CPHA, SPIMode, Endianess;
    logic              SS, TxBusy, RxBusy, WordFlg;

    spi_txn_arbiter #(
        .NumReq(NR), .WordLen(WL), .LenW(LW),
        .SetupCyc(SC), .GapCyc(GC), .TimeoutCyc(TO)
    ) dut (
        .clk(clk), .reset(reset), .Req(Req), .ReqWords(ReqWords),
        .ReqCfg(ReqCfg), .ReqTxData(ReqTxData), .Grant(Grant),
        .TxPop(TxPop), .RxValid(RxValid), .RxData(RxData),
        .Done(Done), .Error(Error), .SlaveSel_n(SlaveSel_n),
        .SPIGo(SPIGo), .CPOL(CPOL), .CPHA(CPHA), .SPIMode(SPIMode),
        .Endianess(Endianess), .SendData(SendData), .SS(SS),
        .TxBusy(TxBusy), .RxBusy(RxBusy), .WordFlg(WordFlg),
        .ReceivedData(ReceivedData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] wdata(int i, int s, int k);
        return 8'((i + 1) * 17 + s * 29 + k * 7);
    endfunction

    // Requesters: step their word on TxPop, restart on Done.
    int txIdx[NR];
    int seed[NR] = '{default: 0};

    always_comb begin
        ReqTxData = '0;
        for (int i = 0; i < NR; i++)
            ReqTxData[i*WL +: WL] = wdata(i, seed[i], txIdx[i]);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) txIdx[i] <= 0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (Grant[i] && Done) begin
                    txIdx[i] <= 0;
                    seed[i]  <= seed[i] + 1;
                end else if (Grant[i] && TxPop) begin
                    txIdx[i] <= txIdx[i] + 1;
                end
            end
        end
    end

    // SPI master: echoes each word, 3 idle clk between words.
    logic       mBusy, stall;
    int         mCnt, gapLeft;
    logic [7:0] mShift;

    assign TxBusy = mBusy;
    assign RxBusy = mBusy;
    assign SS     = !(SPIGo || mBusy);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mBusy        <= 1'b0;
            mCnt         <= 0;
            gapLeft      <= 0;
            WordFlg      <= 1'b0;
            ReceivedData <= '0;
            mShift       <= '0;
        end else begin
            WordFlg <= 1'b0;
            if (!mBusy) begin
                if (gapLeft > 0) begin
                    gapLeft <= gapLeft - 1;
                end else if (SPIGo && !stall) begin
                    mBusy  <= 1'b1;
                    mCnt   <= 0;
                    mShift <= SendData;
                end
            end else if (mCnt == WORD_CYC - 1) begin
                mBusy        <= 1'b0;
                WordFlg      <= 1'b1;
                ReceivedData <= mShift;
                gapLeft      <= 3;
            end else begin
                mCnt <= mCnt + 1;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] expRx[$];
    logic [3:0] expGrant[$];
    int         predSeed[NR] = '{default: 0};

    int cyc = 0;
    int nWordFlg, nTxPop, nRxValid, nDone, nError;
    int lastFlgCyc, doneCyc, zeroRun, goFallWords;
    int grantRiseCyc, setupLat;
    logic       doneErr, doneGo, prevGo, seenGrant;
    logic [3:0] doneSel, prevGrant, selExp, cfgAtW1;

    task automatic clr();
        nWordFlg = 0; nTxPop = 0; nRxValid = 0;
        nDone = 0; nError = 0; goFallWords = -1;
    endtask

    task automatic pushBurst(input int i, input int words);
        for (int k = 0; k < words; k++)
            expRx.push_back(wdata(i, predSeed[i], k));
        predSeed[i]++;
        expGrant.push_back(4'(1 << i));
    endtask

    // One clock: sample on the falling edge and score.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (WordFlg) begin
            nWordFlg++;
            lastFlgCyc = cyc;
            if (nWordFlg == 1) cfgAtW1 = {CPOL, CPHA, SPIMode, Endianess};
            if (selExp != 0) chk("slvsel_word", SlaveSel_n, selExp);
        end
        if (TxPop) nTxPop++;
        if (RxValid) begin
            nRxValid++;
            if (expRx.size() == 0) chk("rx_extra", RxValid, 0);
            else chk("rxdata", RxData, expRx.pop_front());
        end
        if (Done) begin
            nDone++;
            doneCyc = cyc;
            doneErr = Error;
            doneGo  = SPIGo;
            doneSel = SlaveSel_n;
        end
        if (Error) nError++;
        if (Grant != 0 && prevGrant == 0) begin
            if (expGrant.size() == 0) chk("grant_extra", Grant, 0);
            else chk("grant", Grant, expGrant.pop_front());
            if (seenGrant) chk("gap", zeroRun >= GC, 1);
            seenGrant    = 1'b1;
            grantRiseCyc = cyc;
        end
        if (SPIGo && !prevGo) setupLat = cyc - grantRiseCyc;
        if (!SPIGo && prevGo) goFallWords = nWordFlg;
        zeroRun   = (Grant == 0) ? zeroRun + 1 : 0;
        prevGrant = Grant;
        prevGo    = SPIGo;
    endtask

    task automatic waitDone(input int target, input int budget,
                            input string tag);
        int n;
        n = 0;
        while (nDone < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, nDone, target);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int n;
        reset = 1'b1; Req = '0; ReqWords = '0; ReqCfg = '0; stall = 1'b0;
        prevGrant = '0; prevGo = 1'b0; seenGrant = 1'b0; selExp = '0;
        zeroRun = 0; grantRiseCyc = 0; setupLat = -1;
        clr();
        idle(3);
        chk("rst_grant", Grant, 0);
        chk("rst_sel", SlaveSel_n, 4'hF);
        chk("rst_go", SPIGo, 0);
        chk("rst_pulses", {TxPop, RxValid, Done, Error}, 0);
        chk("rst_send", SendData, 0);
        reset = 1'b0;
        idle(2);

        // T2: all requesting, single words, fair rotation from slot 0.
        clr();
        pushBurst(0, 1); pushBurst(1, 1); pushBurst(2, 1);
        pushBurst(3, 1); pushBurst(0, 1);
        Req = 4'hF;
        waitDone(5, 400, "t2_done");
        Req = '0;
        idle(8);
        chk("t2_words", nWordFlg, 5);
        chk("t2_pop", nTxPop, 0);
        chk("t2_rx", nRxValid, 5);

        // T1: three-word burst, mode 0100, select tracks SS.
        clr();
        ReqWords[0 +: LW] = 4'd2;
        ReqCfg[0 +: 4]    = 4'b0100;
        selExp = 4'b1110;
        pushBurst(0, 3);
        Req = 4'b0001;
        waitDone(1, 300, "t1_done");
        chk("t1_sel_ss_hi", doneSel, 4'hF);
        chk("t1_err", doneErr, 0);
        Req = '0;
        selExp = '0;
        idle(8);
        chk("t1_setup", setupLat, SC);
        chk("t1_cfg", cfgAtW1, 4'b0100);
        chk("t1_words", nWordFlg, 3);
        chk("t1_pop", nTxPop, 2);
        chk("t1_rx", nRxValid, 3);
        chk("t1_ndone", nDone, 1);
        chk("t1_sel_idle", SlaveSel_n, 4'hF);

        // T4: longest burst, all-ones word count.
        clr();
        ReqWords[4 +: LW] = 4'hF;
        ReqCfg[4 +: 4]    = 4'b1001;
        pushBurst(1, 16);
        Req = 4'b0010;
        waitDone(1, 600, "t4_done");
        Req = '0;
        idle(8);
        chk("t4_go_fall", goFallWords, 16);
        chk("t4_words", nWordFlg, 16);
        chk("t4_rx", nRxValid, 16);
        chk("t4_pop", nTxPop, 15);

        // T3: pointer at 2 picks slot 3, wraps, then slot 1.
        clr();
        ReqWords[4 +: LW]  = 4'd1;
        ReqWords[12 +: LW] = 4'd1;
        pushBurst(3, 2);
        pushBurst(1, 2);
        Req = 4'b1010;
        waitDone(1, 300, "t3_done1");
        Req = 4'b0010;
        waitDone(2, 300, "t3_done2");
        Req = '0;
        idle(8);
        chk("t3_words", nWordFlg, 4);
        chk("t3_pop", nTxPop, 2);

        // T5: master stalls after two of four words.
        clr();
        ReqWords[0 +: LW] = 4'd3;
        expRx.push_back(wdata(0, predSeed[0], 0));
        expRx.push_back(wdata(0, predSeed[0], 1));
        predSeed[0]++;
        expGrant.push_back(4'b0001);
        Req = 4'b0001;
        n = 0;
        while (nWordFlg < 2 && n < 200) begin
            tick();
            n++;
        end
        chk("t5_two_words", nWordFlg, 2);
        stall = 1'b1;
        waitDone(1, 300, "t5_done");
        Req = '0;
        chk("t5_latency", doneCyc - lastFlgCyc, TO + 1);
        chk("t5_err", doneErr, 1);
        chk("t5_go", doneGo, 0);
        tick();
        chk("t5_grant_off", Grant, 0);
        idle(8);
        stall = 1'b0;
        chk("t5_rx", nRxValid, 2);
        chk("t5_nerr", nError, 1);

        // T6: reset mid-burst, then service restarts from slot 0.
        clr();
        ReqWords[8 +: LW] = 4'd3;
        ReqCfg[8 +: 4]    = 4'b1011;
        expRx.push_back(wdata(2, predSeed[2], 0));
        expGrant.push_back(4'b0100);
        Req = 4'b0100;
        n = 0;
        while (nRxValid < 1 && n < 200) begin
            tick();
            n++;
        end
        chk("t6_in_run", SPIGo, 1);
        reset = 1'b1;
        #1;
        chk("t6_go", SPIGo, 0);
        chk("t6_grant", Grant, 0);
        chk("t6_sel", SlaveSel_n, 4'hF);
        chk("t6_pulses", {TxPop, RxValid, Done, Error}, 0);
        chk("t6_cfg", {CPOL, CPHA, SPIMode, Endianess}, 0);
        chk("t6_send", SendData, 0);
        chk("t6_rxdata", RxData, 0);
        Req = '0;
        tick();
        reset = 1'b0;
        idle(2);
        clr();
        ReqWords[4 +: LW]  = 4'd1;
        ReqWords[12 +: LW] = 4'd1;
        pushBurst(1, 2);
        pushBurst(3, 2);
        Req = 4'b1010;
        waitDone(1, 300, "t6_done1");
        chk("t6_setup", setupLat, SC);
        Req = 4'b1000;
        waitDone(2, 300, "t6_done2");
        Req = '0;
        idle(8);
        chk("t6_pop", nTxPop, 2);

        chk("rx_left", expRx.size(), 0);
        chk("grant_left", expGrant.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
